pipeline_hazard_ctrl: RTL



---
 rtl/pipeline_ctrl_pkg.sv | 18 +
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: divider FSM states,
// the NOP/bubble encoding and the load-detect rule.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    function automatic logic is_load(input logic [1:0] mem_read);
        return mem_read != 2'b00;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// register a load in EX is about to write.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_dest_reg,
    input  logic [1:0] ex_mem_read,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = id_uses_rs1 && (id_rs1 == ex_dest_reg);
        rs2_hit  = id_uses_rs2 && (id_rs2 == ex_dest_reg);
        // x0 is never written, so a load targeting it cannot create a hazard
        load_use = is_load(ex_mem_read) && (ex_dest_reg != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use stalls,
// taken-branch flushes and multi-cycle divider occupancy of EX.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 6
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_RS1,
    input  logic [4:0]  ID_RS2,
    input  logic        ID_USES_RS1,
    input  logic        ID_USES_RS2,
    input  logic [4:0]  EX_DEST_REG,
    input  logic [1:0]  EX_MEM_READ,
    input  logic        EX_IS_DIV,
    input  logic        EX_BRANCH_TAKEN,
    output logic        PC_STALL,
    output logic        IF_ID_STALL,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_STALL,
    output logic        ID_EX_FLUSH,
    output logic        EX_MEM_FLUSH,
    output logic        DIV_START,
    output logic        DIV_DONE,
    output logic [31:0] STALL_CNT
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic             load_use;

    hazard_detect u_hazard_detect (
        .id_rs1      (ID_RS1),
        .id_rs2      (ID_RS2),
        .id_uses_rs1 (ID_USES_RS1),
        .id_uses_rs2 (ID_USES_RS2),
        .ex_dest_reg (EX_DEST_REG),
        .ex_mem_read (EX_MEM_READ),
        .load_use    (load_use)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PC_STALL     = 1'b0;
        IF_ID_STALL  = 1'b0;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_STALL  = 1'b0;
        ID_EX_FLUSH  = 1'b0;
        EX_MEM_FLUSH = 1'b0;
        DIV_START    = 1'b0;
        DIV_DONE     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Divide wins over branch/load if they ever coincide
                if (EX_IS_DIV) begin
                    DIV_START    = 1'b1;
                    PC_STALL     = 1'b1;
                    IF_ID_STALL  = 1'b1;
                    ID_EX_STALL  = 1'b1;
                    EX_MEM_FLUSH = 1'b1;
                    state_d      = RUN;
                    cnt_d        = CNT_W'(DIV_LATENCY - 1);
                end else if (EX_BRANCH_TAKEN) begin
                    IF_ID_FLUSH = 1'b1;
                    ID_EX_FLUSH = 1'b1;
                end else if (load_use) begin
                    PC_STALL    = 1'b1;
                    IF_ID_STALL = 1'b1;
                    ID_EX_FLUSH = 1'b1;
                end
            end
            RUN: begin
                PC_STALL     = 1'b1;
                IF_ID_STALL  = 1'b1;
                ID_EX_STALL  = 1'b1;
                EX_MEM_FLUSH = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                DIV_DONE = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (RESET) begin
            PC_STALL     = 1'b0;
            IF_ID_STALL  = 1'b0;
            IF_ID_FLUSH  = 1'b0;
            ID_EX_STALL  = 1'b0;
            ID_EX_FLUSH  = 1'b0;
            EX_MEM_FLUSH = 1'b0;
            DIV_START    = 1'b0;
            DIV_DONE     = 1'b0;
        end

        stall_cnt_d = stall_cnt_q + (PC_STALL ? 32'd1 : 32'd0);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;

endmodule
